// File: rtl/riscv_pkg.sv
// Shared definitions for the memory-port arbiter: bus width, full byte-enable
// mask and the arbiter state encoding.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [3:0] BE_FULL = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;
endpackage

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: counts busy cycles since the last grant and flags expiry
// once the count reaches TIMEOUT.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= 8'd0;
    end else if (en && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count >= 8'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and the
// MEM stage, with data-first priority, fetch anti-starvation and a watchdog.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_valid,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_be,
  output logic            d_valid,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_err,
  output logic            if_stall,
  output logic            d_stall,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  arb_state_t state, state_nxt;
  logic [3:0] starve_cnt;
  logic       owner_d;
  logic       if_elig, d_elig;
  logic       grant_i, grant_d;
  logic       busy, done, wd_expired;

  // A requester whose valid is already high is finishing; never grant it twice.
  assign if_elig  = if_req & ~if_valid;
  assign d_elig   = d_req & ~d_valid;
  assign busy     = (state == BUSY_I) || (state == BUSY_D);
  assign done     = busy & (mem_ready | wd_expired);
  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (if_elig && d_elig) begin
          if (starve_cnt == 4'(MAX_WAIT)) grant_i = 1'b1;
          else                            grant_d = 1'b1;
        end else begin
          grant_i = if_elig;
          grant_d = d_elig;
        end
        if (grant_i)      state_nxt = BUSY_I;
        else if (grant_d) state_nxt = BUSY_D;
      end
      BUSY_I, BUSY_D: if (mem_ready || wd_expired) state_nxt = RESP;
      RESP:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (grant_i | grant_d),
    .en     (busy),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
      owner_d    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      mem_be     <= 4'h0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      d_valid    <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;

      if (grant_i) begin
        mem_req    <= 1'b1;
        mem_addr   <= if_addr & WORD_MASK;
        mem_we     <= 1'b0;
        mem_wdata  <= '0;
        mem_be     <= BE_FULL;
        owner_d    <= 1'b0;
        starve_cnt <= 4'd0;
      end else if (grant_d) begin
        mem_req   <= 1'b1;
        mem_addr  <= d_addr & WORD_MASK;
        mem_we    <= d_we;
        mem_wdata <= d_wdata;
        mem_be    <= d_we ? d_be : BE_FULL;
        owner_d   <= 1'b1;
        if (if_req && starve_cnt != 4'(MAX_WAIT)) starve_cnt <= starve_cnt + 4'd1;
      end

      // Completion or timeout: a timed-out access returns zero data with err set.
      if (done) begin
        mem_req <= 1'b0;
        if (owner_d) begin
          d_valid <= 1'b1;
          d_err   <= ~mem_ready;
          d_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
        end else begin
          if_valid <= 1'b1;
          if_err   <= ~mem_ready;
          if_rdata <= mem_ready ? mem_rdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter with a behavioural memory responder and
// a response scoreboard.
module tb_mem_port_arbiter;
  import riscv_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int TIMEOUT  = 8;

  logic        clk, rst_n;
  logic        if_req, if_valid, if_err, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_valid, d_err, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   errors = 0;
  int   mem_lat = 1;
  bit   mem_never = 0;
  bit   mem_force = 0;
  int   lat_cnt = 0;

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .if_stall(if_stall), .d_stall(d_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0104) return 32'h0000_0013;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory responder: ready after mem_lat cycles of mem_req, unless stalled forever.
  initial begin
    mem_ready = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (mem_force) begin
        mem_ready = 1;
        mem_rdata = 32'hBAD0_BAD0;
      end else if (mem_req && !mem_never) begin
        if (lat_cnt >= mem_lat - 1) begin
          mem_ready = 1;
          mem_rdata = mem_word(mem_addr);
        end else begin
          mem_ready = 0;
          lat_cnt++;
        end
      end else begin
        mem_ready = 0;
        lat_cnt = 0;
      end
    end
  end

  // Scoreboard: every valid pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_valid || d_valid) begin
        tests++;
        if (if_valid && d_valid) begin
          errors++;
          $display("FAIL sb_double_valid: if_valid=1 d_valid=1, required only one");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: valid pulse (d=%0b) with no pending request", d_valid);
        end else begin
          e = exp_q.pop_front();
          if (e.is_d !== d_valid || e.rdata !== (d_valid ? d_rdata : if_rdata) ||
              e.err !== (d_valid ? d_err : if_err)) begin
            errors++;
            $display("FAIL sb_resp: got d=%0b rdata=%h err=%0b, required d=%0b rdata=%h err=%0b",
                     d_valid, d_valid ? d_rdata : if_rdata, d_valid ? d_err : if_err,
                     e.is_d, e.rdata, e.err);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit is_d, input logic [31:0] rd, input bit err);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rd;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic single_access(input bit is_d, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    push_exp(is_d, (is_d && we) ? 32'h0 : mem_word(addr & 32'hFFFF_FFFC), 1'b0);
    if (is_d) begin
      d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end else begin
      if_req = 1; if_addr = addr;
    end
    while (!seen && n < 300) begin
      tick;
      n++;
      if (is_d ? d_valid : if_valid) seen = 1;
    end
    tests++;
    if (!seen || n != mem_lat + 1) begin
      errors++;
      $display("FAIL access_latency: valid after %0d cycles (seen=%0b), required %0d", n, seen, mem_lat + 1);
    end
    if_req = 0; d_req = 0; d_we = 0;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    tick; tick;
    tests++;
    if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_be !== 0 || mem_wdata !== 0 ||
        if_valid !== 0 || d_valid !== 0 || if_rdata !== 0 || d_rdata !== 0 || if_err !== 0 ||
        d_err !== 0 || dut.starve_cnt !== 0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: mem_req=%0b addr=%h be=%h ifv=%0b dv=%0b starve=%0d state=%0d, required all 0",
               mem_req, mem_addr, mem_be, if_valid, d_valid, dut.starve_cnt, dut.state);
    end
    rst_n = 1;
    tick;
  endtask

  task automatic test_lone_fetch;
    mem_lat = 1;
    push_exp(1'b0, 32'h13, 1'b0);
    if_req = 1; if_addr = 32'h0000_0104;
    #1;
    tests++;
    if (if_stall !== 1) begin errors++; $display("FAIL fetch_stall_n: if_stall=%0b required 1", if_stall); end
    tick;
    tests++;
    if (mem_req !== 1 || mem_addr !== 32'h104 || mem_we !== 0 || mem_be !== 4'hF || if_stall !== 1) begin
      errors++;
      $display("FAIL fetch_issue: mem_req=%0b addr=%h we=%0b be=%h stall=%0b, required 1 00000104 0 f 1",
               mem_req, mem_addr, mem_we, mem_be, if_stall);
    end
    tick;
    tests++;
    if (if_valid !== 1 || if_rdata !== 32'h13 || if_err !== 0 || if_stall !== 0 || d_valid !== 0) begin
      errors++;
      $display("FAIL fetch_resp: if_valid=%0b rdata=%h err=%0b stall=%0b d_valid=%0b, required 1 00000013 0 0 0",
               if_valid, if_rdata, if_err, if_stall, d_valid);
    end
    if_req = 0;
    tick;
    tests++;
    if (mem_req !== 0 || if_valid !== 0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL fetch_idle: mem_req=%0b if_valid=%0b state=%0d, required 0 0 0", mem_req, if_valid, dut.state);
    end
  endtask

  task automatic test_simultaneous;
    int dc, ic;
    dc = -1; ic = -1;
    mem_lat = 1;
    push_exp(1'b1, mem_word(32'h2000), 1'b0);
    push_exp(1'b0, mem_word(32'h200), 1'b0);
    if_req = 1; if_addr = 32'h200;
    d_req = 1; d_we = 0; d_addr = 32'h2000;
    for (int c = 1; c <= 20 && ic < 0; c++) begin
      tick;
      if (d_valid) begin dc = c; d_req = 0; end
      tests++;
      if (if_valid) begin
        ic = c;
        if (if_stall !== 0) begin errors++; $display("FAIL simul_stall_end: if_stall=%0b required 0", if_stall); end
      end else if (if_stall !== 1) begin
        errors++;
        $display("FAIL simul_stall: cycle %0d if_stall=%0b required 1", c, if_stall);
      end
    end
    if_req = 0;
    tests++;
    if (dc != 2 || ic - dc != 3) begin
      errors++;
      $display("FAIL simul_order: d_valid at %0d if_valid at %0d, required 2 and 5", dc, ic);
    end
    tick;
  endtask

  task automatic test_starvation;
    int nd, prev_starve;
    bit fstart, seen;
    nd = 0; prev_starve = -1; fstart = 0; seen = 0;
    mem_lat = 1;
    tests++;
    if (dut.starve_cnt !== 0) begin errors++; $display("FAIL starve_init: starve_cnt=%0d required 0", dut.starve_cnt); end
    for (int k = 0; k < 4; k++) push_exp(1'b1, mem_word(32'h3000), 1'b0);
    push_exp(1'b0, mem_word(32'h300), 1'b0);
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_we = 0; d_addr = 32'h3000;
    for (int c = 0; c < 60 && !seen; c++) begin
      tick;
      if (d_valid) nd++;
      if (mem_req && mem_addr == 32'h300 && !fstart) begin
        fstart = 1;
        tests++;
        if (prev_starve != MAX_WAIT || dut.starve_cnt !== 0) begin
          errors++;
          $display("FAIL starve_cnt: %0d then %0d, required 4 then 0", prev_starve, dut.starve_cnt);
        end
      end
      prev_starve = dut.starve_cnt;
      if (if_valid) begin seen = 1; if_req = 0; d_req = 0; end
    end
    tests++;
    if (!seen || !fstart || nd != MAX_WAIT) begin
      errors++;
      $display("FAIL starve_grant: data grants before fetch=%0d fetch_done=%0b, required 4 1", nd, seen);
    end
    tick;
  endtask

  task automatic test_store;
    mem_lat = 1;
    push_exp(1'b1, 32'h0, 1'b0);
    d_req = 1; d_we = 1; d_addr = 32'h1003; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    tick;
    tests++;
    if (mem_req !== 1 || mem_we !== 1 || mem_be !== 4'b0011 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h1000) begin
      errors++;
      $display("FAIL store_issue: req=%0b we=%0b be=%b wdata=%h addr=%h, required 1 1 0011 deadbeef 00001000",
               mem_req, mem_we, mem_be, mem_wdata, mem_addr);
    end
    tick;
    tests++;
    if (d_valid !== 1 || d_rdata !== 0 || d_err !== 0) begin
      errors++;
      $display("FAIL store_resp: d_valid=%0b d_rdata=%h d_err=%0b, required 1 0 0", d_valid, d_rdata, d_err);
    end
    d_req = 0; d_we = 0;
    tick;
  endtask

  task automatic test_timeout;
    mem_never = 1;
    push_exp(1'b1, 32'h0, 1'b1);
    d_req = 1; d_we = 0; d_addr = 32'h40;
    tick;
    tests++;
    if (mem_req !== 1) begin errors++; $display("FAIL timeout_issue: mem_req=%0b required 1", mem_req); end
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick;
      tests++;
      if (d_valid !== 0 || mem_req !== 1) begin
        errors++;
        $display("FAIL timeout_wait: T+%0d d_valid=%0b mem_req=%0b, required 0 1", k, d_valid, mem_req);
      end
    end
    tick;
    tests++;
    if (d_valid !== 1 || d_err !== 1 || d_rdata !== 0 || mem_req !== 0) begin
      errors++;
      $display("FAIL timeout_resp: d_valid=%0b d_err=%0b d_rdata=%h mem_req=%0b, required 1 1 0 0",
               d_valid, d_err, d_rdata, mem_req);
    end
    d_req = 0;
    mem_never = 0;
    tick;
    tests++;
    if (mem_req !== 0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL timeout_idle: mem_req=%0b state=%0d, required 0 0", mem_req, dut.state);
    end
    single_access(1'b0, 1'b0, 32'h104, 32'h0, 4'h0);
  endtask

  task automatic test_reset_mid;
    mem_never = 1;
    d_req = 1; d_we = 0; d_addr = 32'h80;
    tick; tick;
    tests++;
    if (dut.state !== BUSY_D || mem_req !== 1) begin
      errors++;
      $display("FAIL rstmid_busy: state=%0d mem_req=%0b, required 2 1", dut.state, mem_req);
    end
    rst_n = 0; d_req = 0;
    tick;
    tests++;
    if (mem_req !== 0 || dut.state !== IDLE || d_valid !== 0 || dut.starve_cnt !== 0) begin
      errors++;
      $display("FAIL rstmid_reset: mem_req=%0b state=%0d d_valid=%0b starve=%0d, required 0 0 0 0",
               mem_req, dut.state, d_valid, dut.starve_cnt);
    end
    rst_n = 1; mem_never = 0; mem_force = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      tests++;
      if (d_valid !== 0 || if_valid !== 0 || mem_req !== 0 || dut.state !== IDLE) begin
        errors++;
        $display("FAIL rstmid_late_ready: d_valid=%0b if_valid=%0b mem_req=%0b state=%0d, required 0 0 0 0",
                 d_valid, if_valid, mem_req, dut.state);
      end
    end
    mem_force = 0;
    tick;
  endtask

  task automatic test_back_to_back;
    bit is_d, we;
    logic [31:0] a;
    for (int k = 0; k < 8; k++) begin
      mem_lat = $urandom_range(1, 3);
      is_d = 1'($urandom_range(0, 1));
      we = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      a = $urandom & 32'h0000_FFFF;
      single_access(is_d, we, a, $urandom, 4'($urandom_range(1, 15)));
    end
    mem_lat = 1;
  endtask

  initial begin
    test_reset;
    test_lone_fetch;
    test_simultaneous;
    test_starvation;
    test_store;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    tick; tick;
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses missing, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
